// File: rtl/mr_wb_arb_pkg.sv
// Shared typedefs for the mr_wb_arb Wishbone arbiter.
package mr_wb_arb_pkg;

  // Core word size and the number of byte-address bits below a word.
  localparam int XLEN      = 32;
  localparam int XLEN_GRAN = 2;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    DRAIN = 2'd3
  } e_arbstate;

endpackage

// File: rtl/mr_wb_arb.sv
// Two-master to one-slave pipelined Wishbone arbiter.
// Master 0 is ifetch, master 1 is load/store. A master keeps the bus for a whole
// cyc burst. Outstanding strobes are counted so that acks belonging to an
// abandoned burst are swallowed in DRAIN instead of reaching the next owner.
module mr_wb_arb
  import mr_wb_arb_pkg::*;
#(
  parameter int ADR_W   = XLEN - XLEN_GRAN,
  parameter int DAT_W   = XLEN,
  parameter int MAX_OUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  // master 0 (ifetch)
  input  logic [ADR_W-1:0]   m0_adr_i,
  input  logic [DAT_W-1:0]   m0_dat_i,
  input  logic               m0_we_i,
  input  logic [DAT_W/8-1:0] m0_sel_i,
  input  logic               m0_stb_i,
  input  logic               m0_cyc_i,
  output logic [DAT_W-1:0]   m0_dat_o,
  output logic               m0_ack_o,
  output logic               m0_err_o,
  output logic               m0_stall_o,
  // master 1 (load/store)
  input  logic [ADR_W-1:0]   m1_adr_i,
  input  logic [DAT_W-1:0]   m1_dat_i,
  input  logic               m1_we_i,
  input  logic [DAT_W/8-1:0] m1_sel_i,
  input  logic               m1_stb_i,
  input  logic               m1_cyc_i,
  output logic [DAT_W-1:0]   m1_dat_o,
  output logic               m1_ack_o,
  output logic               m1_err_o,
  output logic               m1_stall_o,
  // slave
  output logic [ADR_W-1:0]   s_adr_o,
  output logic [DAT_W-1:0]   s_dat_o,
  output logic               s_we_o,
  output logic [DAT_W/8-1:0] s_sel_o,
  output logic               s_stb_o,
  output logic               s_cyc_o,
  input  logic [DAT_W-1:0]   s_dat_i,
  input  logic               s_ack_i,
  input  logic               s_err_i,
  input  logic               s_stall_i
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

  e_arbstate     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;   // 1: master 1 was granted most recently

  logic accept, ack_in, dec, cap;

  assign cap = (cnt_q == CNT_MAX);

  // Read data is broadcast; only the ack qualifies it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Request/response muxing on the current owner; idle and drain keep masters stalled.
  always_comb begin
    s_adr_o    = '0;
    s_dat_o    = '0;
    s_we_o     = 1'b0;
    s_sel_o    = '0;
    s_stb_o    = 1'b0;
    s_cyc_o    = 1'b0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_stall_o = 1'b1;
    case (state_q)
      OWN0: begin
        s_adr_o    = m0_adr_i;
        s_dat_o    = m0_dat_i;
        s_we_o     = m0_we_i;
        s_sel_o    = m0_sel_i;
        s_cyc_o    = m0_cyc_i;
        s_stb_o    = m0_stb_i & m0_cyc_i & ~cap;
        m0_stall_o = s_stall_i | cap;
        m0_ack_o   = s_ack_i;
        m0_err_o   = s_err_i;
      end
      OWN1: begin
        s_adr_o    = m1_adr_i;
        s_dat_o    = m1_dat_i;
        s_we_o     = m1_we_i;
        s_sel_o    = m1_sel_i;
        s_cyc_o    = m1_cyc_i;
        s_stb_o    = m1_stb_i & m1_cyc_i & ~cap;
        m1_stall_o = s_stall_i | cap;
        m1_ack_o   = s_ack_i;
        m1_err_o   = s_err_i;
      end
      DRAIN: s_cyc_o = 1'b1;  // hold the cycle open while stale acks return
      default: ;
    endcase
  end

  // Outstanding-transfer count: err counts as an ack, stray acks at zero are dropped.
  always_comb begin
    accept = s_stb_o & ~s_stall_i;
    ack_in = s_ack_i | s_err_i;
    dec    = ack_in & ((cnt_q != '0) | accept);
    cnt_d  = cnt_q;
    if (accept && !dec)      cnt_d = cnt_q + CW'(1);
    else if (!accept && dec) cnt_d = cnt_q - CW'(1);
  end

  // Ownership FSM with round-robin tie break on last grant.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m1_cyc_i && (!m0_cyc_i || !last_q)) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end else if (m0_cyc_i) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end
      end
      OWN0:  if (!m0_cyc_i) state_d = (cnt_d == '0) ? IDLE : DRAIN;
      OWN1:  if (!m1_cyc_i) state_d = (cnt_d == '0) ? IDLE : DRAIN;
      DRAIN: if (cnt_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mr_wb_arb.sv
// Directed bench for mr_wb_arb: grant, round-robin, outstanding cap, drain, reset.
module tb_mr_wb_arb;
  import mr_wb_arb_pkg::*;

  localparam int ADR_W = XLEN - XLEN_GRAN;
  localparam int DAT_W = XLEN;

  logic               clk, rst;
  logic [ADR_W-1:0]   m0_adr_i, m1_adr_i, s_adr_o;
  logic [DAT_W-1:0]   m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic               m0_we_i, m1_we_i, s_we_o;
  logic [DAT_W/8-1:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic               m0_stb_i, m0_cyc_i, m1_stb_i, m1_cyc_i;
  logic               m0_ack_o, m0_err_o, m0_stall_o;
  logic               m1_ack_o, m1_err_o, m1_stall_o;
  logic               s_stb_o, s_cyc_o, s_ack_i, s_err_i, s_stall_i;

  int checks = 0;
  int failures = 0;

  mr_wb_arb #(.ADR_W(ADR_W), .DAT_W(DAT_W), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_stall_i(s_stall_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling, well clear of the edge.
  task automatic settle();
    #4;
  endtask

  initial begin
    rst = 1'b1;
    m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 1'b0; m0_sel_i = '0; m0_stb_i = 1'b0; m0_cyc_i = 1'b0;
    m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_sel_i = '0; m1_stb_i = 1'b0; m1_cyc_i = 1'b0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_stall_i = 1'b0;
    step(); step();
    settle();
    chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
    chk("rst_s_stb", 64'(s_stb_o), 64'd0);
    chk("rst_s_adr", 64'(s_adr_o), 64'd0);
    chk("rst_m0_stall", 64'(m0_stall_o), 64'd1);
    chk("rst_m1_stall", 64'(m1_stall_o), 64'd1);
    chk("rst_m0_ack", 64'(m0_ack_o), 64'd0);
    chk("rst_cnt", 64'(dut.cnt_q), 64'd0);
    step();
    rst = 1'b0;

    // Lone master 1 read at 0x100, acked one cycle after the strobe.
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = ADR_W'(32'h100); m1_sel_i = 4'hf;
    settle();
    chk("m1_req_idle_stall", 64'(m1_stall_o), 64'd1);
    chk("m1_req_idle_cyc", 64'(s_cyc_o), 64'd0);
    step();
    settle();
    chk("m1_grant_adr", 64'(s_adr_o), 64'h100);
    chk("m1_grant_stb", 64'(s_stb_o), 64'd1);
    chk("m1_grant_sel", 64'(s_sel_o), 64'hf);
    chk("m1_grant_stall", 64'(m1_stall_o), 64'd0);
    chk("m1_grant_m0_stall", 64'(m0_stall_o), 64'd1);
    step();
    m1_stb_i = 1'b0; s_ack_i = 1'b1; s_dat_i = 32'hdeadbeef;
    settle();
    chk("m1_ack", 64'(m1_ack_o), 64'd1);
    chk("m1_ack_m0_ack", 64'(m0_ack_o), 64'd0);
    chk("m1_dat", 64'(m1_dat_o), 64'hdeadbeef);
    chk("m1_ack_m0_stall", 64'(m0_stall_o), 64'd1);
    step();
    s_ack_i = 1'b0; m1_cyc_i = 1'b0;
    settle();
    chk("m1_ack_one_cycle", 64'(m1_ack_o), 64'd0);
    chk("m1_cnt_zero", 64'(dut.cnt_q), 64'd0);
    step();
    settle();
    chk("m1_release_cyc", 64'(s_cyc_o), 64'd0);
    chk("m1_release_stall", 64'(m1_stall_o), 64'd1);

    // Tie after reset-state last=1 goes to master 0, the next tie to master 1.
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    step();
    settle();
    chk("tie1_m0_stall", 64'(m0_stall_o), 64'd0);
    chk("tie1_m1_stall", 64'(m1_stall_o), 64'd1);
    chk("tie1_cyc", 64'(s_cyc_o), 64'd1);
    m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
    step();
    settle();
    chk("tie_idle_cyc", 64'(s_cyc_o), 64'd0);
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    step();
    settle();
    chk("tie2_m1_stall", 64'(m1_stall_o), 64'd0);
    chk("tie2_m0_stall", 64'(m0_stall_o), 64'd1);
    m1_cyc_i = 1'b0;
    step();
    settle();
    chk("rr_idle_m0_stall", 64'(m0_stall_o), 64'd1);
    chk("rr_idle_cyc", 64'(s_cyc_o), 64'd0);
    step();
    settle();
    chk("rr_own0_m0_stall", 64'(m0_stall_o), 64'd0);

    // Outstanding cap: master 0 streams, slave silent until the cap is hit.
    m0_stb_i = 1'b1; m0_adr_i = ADR_W'(32'h40);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("cap_acc%0d_stb", i), 64'(s_stb_o), 64'd1);
      chk($sformatf("cap_acc%0d_stall", i), 64'(m0_stall_o), 64'd0);
      step();
    end
    s_ack_i = 1'b1;
    settle();
    chk("cap_full_stall", 64'(m0_stall_o), 64'd1);
    chk("cap_full_stb", 64'(s_stb_o), 64'd0);
    chk("cap_full_cnt", 64'(dut.cnt_q), 64'd4);
    step();
    s_ack_i = 1'b0;
    settle();
    chk("cap_fifth_cnt", 64'(dut.cnt_q), 64'd3);
    chk("cap_fifth_stb", 64'(s_stb_o), 64'd1);
    chk("cap_fifth_stall", 64'(m0_stall_o), 64'd0);
    step();
    m0_stb_i = 1'b0; s_ack_i = 1'b1;
    settle();
    chk("cap_refill_cnt", 64'(dut.cnt_q), 64'd4);
    step();
    step();
    // Simultaneous accept and ack at cnt=2.
    m0_stb_i = 1'b1; s_ack_i = 1'b1;
    settle();
    chk("simul_pre_cnt", 64'(dut.cnt_q), 64'd2);
    chk("simul_stb", 64'(s_stb_o), 64'd1);
    step();
    s_ack_i = 1'b0;
    settle();
    chk("simul_post_cnt", 64'(dut.cnt_q), 64'd2);
    step();

    // Abort with 3 outstanding while master 1 waits.
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b1;
    settle();
    chk("abort_cnt", 64'(dut.cnt_q), 64'd3);
    chk("abort_m1_stall", 64'(m1_stall_o), 64'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      s_ack_i = 1'b1;
      settle();
      chk($sformatf("drain%0d_cyc", i), 64'(s_cyc_o), 64'd1);
      chk($sformatf("drain%0d_stb", i), 64'(s_stb_o), 64'd0);
      chk($sformatf("drain%0d_m0_ack", i), 64'(m0_ack_o), 64'd0);
      chk($sformatf("drain%0d_m1_ack", i), 64'(m1_ack_o), 64'd0);
      chk($sformatf("drain%0d_m1_stall", i), 64'(m1_stall_o), 64'd1);
      step();
    end
    s_ack_i = 1'b0;
    settle();
    chk("drain_done_cyc", 64'(s_cyc_o), 64'd0);
    chk("drain_done_m1_stall", 64'(m1_stall_o), 64'd1);
    step();
    settle();
    chk("drain_m1_grant", 64'(m1_stall_o), 64'd0);
    chk("drain_m1_cyc", 64'(s_cyc_o), 64'd1);

    // Reset mid-burst in OWN1 with two outstanding.
    m1_stb_i = 1'b1;
    step();
    step();
    m1_stb_i = 1'b0;
    settle();
    chk("rstmid_pre_cnt", 64'(dut.cnt_q), 64'd2);
    rst = 1'b1;
    step();
    settle();
    chk("rstmid_cyc", 64'(s_cyc_o), 64'd0);
    chk("rstmid_m1_stall", 64'(m1_stall_o), 64'd1);
    chk("rstmid_cnt", 64'(dut.cnt_q), 64'd0);
    rst = 1'b0; m1_cyc_i = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
